cpipe_ctl_pipe: RTL and testbench

- Parametrised, pipelined successor to the flat CPIPE2 control-word PLA decoder.
- Carries control words through DEPTH registered stages with a valid bit per stage, and decodes the oldest stage into control strobes.
- Adds a ready/valid input, external stall/flush, a load-use interlock that inserts bubbles, nil-on-return squash of younger stages, and a bubble counter.
- Sits between instruction issue and the register-file/bus control logic.

---
 rtl/cpipe_pkg.sv | 36 +++
 rtl/cpipe_stage_reg.sv | 45 ++++
 rtl/cpipe_ctl_pipe.sv | 124 ++++++++++++
 tb/tb_cpipe_ctl_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpipe_pkg.sv
// Shared constants, decoded-strobe struct and the control-word decode function
// for the pipelined control-word decoder.
package cpipe_pkg;

    localparam int CP_B0 = 0;
    localparam int CP_B1 = 1;
    localparam int CP_B2 = 2;
    localparam int CP_B3 = 3;
    localparam int CP_B4 = 4;
    localparam int CP_B5 = 5;
    localparam int CP_B6 = 6;
    localparam int CP_B7 = 7;

    localparam int CP_LOAD_STALL_DEF = 1;

    typedef struct packed {
        logic write_rf;
        logic last_pc_to_busd;
        logic nil_on_return;
        logic pload_write;
        logic opc2load;
    } cpipe_ctl_t;

    // Bit 6 is not part of any product term.
    function automatic cpipe_ctl_t cpipe_decode(input logic [7:0] b);
        cpipe_ctl_t c;
        c.nil_on_return   = b[CP_B7] & ~b[CP_B5] & ~b[CP_B4] & b[CP_B1] & b[CP_B3];
        c.pload_write     = b[CP_B7] & b[CP_B5] & b[CP_B4] & ~b[CP_B3];
        c.opc2load        = c.pload_write & ~b[CP_B2] & ~b[CP_B1] & ~b[CP_B0];
        c.last_pc_to_busd = ~b[CP_B5] & (~b[CP_B7] |
                            (b[CP_B0] & ~b[CP_B1] & b[CP_B2] & ~b[CP_B3] & ~b[CP_B4]));
        c.write_rf        = c.last_pc_to_busd | (b[CP_B7] & b[CP_B5] & ~b[CP_B4]);
        return c;
    endfunction

endpackage

// File: rtl/cpipe_stage_reg.sv
// One pipeline slot: a valid bit plus its control word.
// Priority is clear > hold > load.
module cpipe_stage_reg
    import cpipe_pkg::*;
#(
    parameter int CW_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold_i,
    input  logic                clr_i,
    input  logic                vld_i,
    input  logic [CW_WIDTH-1:0] cw_i,
    output logic                vld_o,
    output logic [CW_WIDTH-1:0] cw_o
);

    logic                vld_q, vld_d;
    logic [CW_WIDTH-1:0] cw_q, cw_d;

    always_comb begin
        vld_d = vld_q;
        cw_d  = cw_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (!hold_i) begin
            vld_d = vld_i;
            cw_d  = cw_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            cw_q  <= '0;
        end else begin
            vld_q <= vld_d;
            cw_q  <= cw_d;
        end
    end

    assign vld_o = vld_q;
    assign cw_o  = cw_q;

endmodule

// File: rtl/cpipe_ctl_pipe.sv
// Pipelined control-word decoder: DEPTH valid/word stages, ready/valid input,
// stall/flush, load-use bubble interlock, nil-on-return squash, bubble counter.
module cpipe_ctl_pipe
    import cpipe_pkg::*;
#(
    parameter int CW_WIDTH   = 8,
    parameter int DEPTH      = 3,
    parameter int LOAD_STALL = CP_LOAD_STALL_DEF,
    parameter int PERF_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CW_WIDTH-1:0] cw_in,
    input  logic                cw_valid,
    output logic                cw_ready,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [CW_WIDTH-1:0] cw_out,
    output logic                cw_out_valid,
    output logic                write_rf,
    output logic                last_pc_to_busd,
    output logic                nil_on_return,
    output logic                pload_write,
    output logic                opc2load,
    output logic                interlock,
    output logic [PERF_W-1:0]   perf_bubbles
);

    localparam int LU_W = (LOAD_STALL < 1) ? 1 : $clog2(LOAD_STALL + 1);

    logic                stg_vld [DEPTH];
    logic [CW_WIDTH-1:0] stg_cw  [DEPTH];

    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    cpipe_ctl_t dec_raw, dec, dec_next;
    logic       adv, squash, shift, load_enters;

    assign dec_raw  = cpipe_decode(stg_cw[DEPTH-1][7:0]);
    assign dec      = stg_vld[DEPTH-1] ? dec_raw : '0;
    assign dec_next = cpipe_decode(stg_cw[DEPTH-2][7:0]);

    assign adv       = ~stall_i & ~flush_i;
    assign interlock = (lu_cnt_q != '0);
    assign squash    = dec.nil_on_return & adv;
    assign shift     = adv & ~interlock & ~squash;
    assign cw_ready  = ~stall_i & ~interlock & ~squash;

    // A load is about to move into the decode stage on this edge.
    assign load_enters = shift & stg_vld[DEPTH-2] & dec_next.opc2load;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                hold_k, clr_k, vld_in_k;
        logic [CW_WIDTH-1:0] cw_in_k;

        if (k == 0) begin : g_head
            assign vld_in_k = cw_valid & cw_ready;
            assign cw_in_k  = cw_in;
        end else begin : g_body
            assign vld_in_k = stg_vld[k-1];
            assign cw_in_k  = stg_cw[k-1];
        end

        // Younger stages freeze during an interlock; the decode stage takes a bubble.
        if (k == DEPTH - 1) begin : g_dec
            assign hold_k = stall_i;
            assign clr_k  = flush_i | (adv & (interlock | squash));
        end else begin : g_young
            assign hold_k = stall_i | interlock;
            assign clr_k  = flush_i | (squash & ~interlock);
        end

        cpipe_stage_reg #(
            .CW_WIDTH (CW_WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold_i (hold_k),
            .clr_i  (clr_k),
            .vld_i  (vld_in_k),
            .cw_i   (cw_in_k),
            .vld_o  (stg_vld[k]),
            .cw_o   (stg_cw[k])
        );
    end

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        perf_d   = perf_q;
        if (flush_i) begin
            lu_cnt_d = '0;
        end else if (adv) begin
            if (interlock) begin
                lu_cnt_d = lu_cnt_q - LU_W'(1);
                if (perf_q != '1) begin
                    perf_d = perf_q + PERF_W'(1);
                end
            end else if (load_enters) begin
                lu_cnt_d = LU_W'(LOAD_STALL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            perf_q   <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            perf_q   <= perf_d;
        end
    end

    assign cw_out          = stg_vld[DEPTH-1] ? stg_cw[DEPTH-1] : '0;
    assign cw_out_valid    = stg_vld[DEPTH-1];
    assign write_rf        = dec.write_rf;
    assign last_pc_to_busd = dec.last_pc_to_busd;
    assign nil_on_return   = dec.nil_on_return;
    assign pload_write     = dec.pload_write;
    assign opc2load        = dec.opc2load;
    assign perf_bubbles    = perf_q;

endmodule

// File: tb/tb_cpipe_ctl_pipe.sv
// Directed bench for cpipe_ctl_pipe: decode table plus latency, interlock,
// squash, stall, flush and async-reset sequences.
module tb_cpipe_ctl_pipe;

    localparam int CW_WIDTH   = 12;
    localparam int DEPTH      = 3;
    localparam int LOAD_STALL = 2;
    localparam int PERF_W     = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CW_WIDTH-1:0] cw_in = '0;
    logic                cw_valid = 1'b0;
    logic                cw_ready;
    logic                stall_i = 1'b0;
    logic                flush_i = 1'b0;
    logic [CW_WIDTH-1:0] cw_out;
    logic                cw_out_valid;
    logic                write_rf, last_pc_to_busd, nil_on_return, pload_write, opc2load;
    logic                interlock;
    logic [PERF_W-1:0]   perf_bubbles;

    int errors = 0;
    int checks = 0;

    cpipe_ctl_pipe #(
        .CW_WIDTH   (CW_WIDTH),
        .DEPTH      (DEPTH),
        .LOAD_STALL (LOAD_STALL),
        .PERF_W     (PERF_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cw_in           (cw_in),
        .cw_valid        (cw_valid),
        .cw_ready        (cw_ready),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cw_out          (cw_out),
        .cw_out_valid    (cw_out_valid),
        .write_rf        (write_rf),
        .last_pc_to_busd (last_pc_to_busd),
        .nil_on_return   (nil_on_return),
        .pload_write     (pload_write),
        .opc2load        (opc2load),
        .interlock       (interlock),
        .perf_bubbles    (perf_bubbles)
    );

    always #5 clk = ~clk;

    // {write_rf, last_pc_to_busd, nil_on_return, pload_write, opc2load}
    logic [4:0] ctl;
    assign ctl = {write_rf, last_pc_to_busd, nil_on_return, pload_write, opc2load};

    typedef struct {
        logic [7:0] w;
        logic [3:0] tag;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cw_valid = 1'b0;
        cw_in    = '0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{w: 8'h00, tag: 4'h1, exp: 5'b11000};
        vecs[1] = '{w: 8'hA0, tag: 4'h2, exp: 5'b10000};
        vecs[2] = '{w: 8'h8A, tag: 4'h3, exp: 5'b00100};
        vecs[3] = '{w: 8'hB0, tag: 4'h4, exp: 5'b00011};
        vecs[4] = '{w: 8'h85, tag: 4'h5, exp: 5'b11000};
        vecs[5] = '{w: 8'hB3, tag: 4'h6, exp: 5'b00010};
        vecs[6] = '{w: 8'hA8, tag: 4'h7, exp: 5'b10000};
        vecs[7] = '{w: 8'h9A, tag: 4'h8, exp: 5'b00000};
        vecs[8] = '{w: 8'h7F, tag: 4'h9, exp: 5'b00000};
        vecs[9] = '{w: 8'h5F, tag: 4'hF, exp: 5'b11000};

        do_reset();
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_valid", 32'(cw_out_valid), 32'h0);
        chk("rst_cw_out", 32'(cw_out), 32'h0);
        chk("rst_ready", 32'(cw_ready), 32'h1);
        chk("rst_interlock", 32'(interlock), 32'h0);
        chk("rst_perf", 32'(perf_bubbles), 32'h0);

        // Decode table: one isolated word, checked when it reaches decode.
        for (int i = 0; i < 10; i++) begin
            cw_in    = {vecs[i].tag, vecs[i].w};
            cw_valid = 1'b1;
            step();
            cw_valid = 1'b0;
            step();
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(cw_out_valid), 32'h1);
            chk($sformatf("tbl%0d_cw_out", i), 32'(cw_out), 32'({vecs[i].tag, vecs[i].w}));
            chk($sformatf("tbl%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
            repeat (4) step();
        end

        // Latency and first/last decode of a back-to-back stream.
        do_reset();
        cw_in = 12'h000; cw_valid = 1'b1;
        step();
        chk("lat_e1_valid", 32'(cw_out_valid), 32'h0);
        cw_in = 12'h0A0;
        step();
        chk("lat_e2_valid", 32'(cw_out_valid), 32'h0);
        cw_valid = 1'b0;
        step();
        chk("lat_e3_valid", 32'(cw_out_valid), 32'h1);
        chk("lat_00_ctl", 32'(ctl), 32'b11000);
        step();
        chk("lat_A0_cw", 32'(cw_out), 32'h0A0);
        chk("lat_A0_ctl", 32'(ctl), 32'b10000);

        // Async reset mid-stream clears outputs without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(cw_out_valid), 32'h0);
        chk("arst_ctl", 32'(ctl), 32'h0);
        chk("arst_cw_out", 32'(cw_out), 32'h0);
        do_reset();

        // Load interlock with LOAD_STALL=2.
        cw_in = 12'h0B0; cw_valid = 1'b1;
        step();
        cw_in = 12'h000;
        step();
        cw_valid = 1'b0;
        step();
        chk("ld_ctl", 32'(ctl), 32'b00011);
        chk("ld_interlock0", 32'(interlock), 32'h1);
        chk("ld_ready0", 32'(cw_ready), 32'h0);
        step();
        chk("ld_b1_valid", 32'(cw_out_valid), 32'h0);
        chk("ld_b1_interlock", 32'(interlock), 32'h1);
        chk("ld_b1_ready", 32'(cw_ready), 32'h0);
        step();
        chk("ld_b2_valid", 32'(cw_out_valid), 32'h0);
        chk("ld_b2_interlock", 32'(interlock), 32'h0);
        step();
        chk("ld_next_valid", 32'(cw_out_valid), 32'h1);
        chk("ld_next_cw", 32'(cw_out), 32'h000);
        chk("ld_next_ctl", 32'(ctl), 32'b11000);
        chk("ld_perf", 32'(perf_bubbles), 32'h2);

        // Squash: younger words and the same-cycle input are dropped.
        do_reset();
        cw_in = 12'h08A; cw_valid = 1'b1;
        step();
        cw_in = 12'h001;
        step();
        cw_in = 12'h002;
        step();
        cw_in = 12'h003;
        chk("sq_nil", 32'(nil_on_return), 32'h1);
        chk("sq_ready", 32'(cw_ready), 32'h0);
        step();
        cw_valid = 1'b0;
        chk("sq_e4_valid", 32'(cw_out_valid), 32'h0);
        step();
        chk("sq_e5_valid", 32'(cw_out_valid), 32'h0);
        step();
        chk("sq_e6_valid", 32'(cw_out_valid), 32'h0);

        // Stall held for 4 cycles during an interlock.
        do_reset();
        cw_in = 12'h0B0; cw_valid = 1'b1;
        step();
        cw_in = 12'h000;
        step();
        cw_valid = 1'b0;
        step();
        stall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("st%0d_cw", c), 32'(cw_out), 32'h0B0);
            chk($sformatf("st%0d_interlock", c), 32'(interlock), 32'h1);
            chk($sformatf("st%0d_perf", c), 32'(perf_bubbles), 32'h0);
        end
        stall_i = 1'b0;
        step();
        chk("st_r1_valid", 32'(cw_out_valid), 32'h0);
        chk("st_r1_perf", 32'(perf_bubbles), 32'h1);
        step();
        chk("st_r2_interlock", 32'(interlock), 32'h0);
        chk("st_r2_perf", 32'(perf_bubbles), 32'h2);
        step();
        chk("st_r3_cw", 32'(cw_out), 32'h000);
        chk("st_r3_valid", 32'(cw_out_valid), 32'h1);

        // Flush with stall during an active interlock.
        do_reset();
        cw_in = 12'h0B0; cw_valid = 1'b1;
        step();
        cw_in = 12'h000;
        step();
        cw_valid = 1'b0;
        step();
        step();
        chk("fl_pre_interlock", 32'(interlock), 32'h1);
        chk("fl_pre_perf", 32'(perf_bubbles), 32'h1);
        stall_i = 1'b1;
        flush_i = 1'b1;
        step();
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("fl_valid", 32'(cw_out_valid), 32'h0);
        chk("fl_interlock", 32'(interlock), 32'h0);
        chk("fl_ready", 32'(cw_ready), 32'h1);
        chk("fl_perf", 32'(perf_bubbles), 32'h1);
        step();
        chk("fl_e6_valid", 32'(cw_out_valid), 32'h0);
        step();
        chk("fl_e7_valid", 32'(cw_out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
